rvpi_master_port: RTL
=====================

Name: rvpi_master_port

Overview:
Master-side controller for the shared slave memory (32 words x 12 bits, 5-bit address). It drives the master leg of the existing access mux (has_control / read_addr / write_addr / write) and reads back the memory read node. It executes single or burst read/write commands from a host-side valid/ready command channel and returns read data on a response channel. Between commands it releases control so the slave runs undisturbed.

Parameters:
ADDR_W, 5, memory address width
DATA_W, 12, memory word width
READ_LATENCY, 1, cycles from master_read_addr change to valid read_node (legal 0..3)
SWITCH_CYCLES, 2, guard cycles after raising/before dropping master_has_control (legal 1..7)

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start address
cmd_len  in  ADDR_W  burst length minus one (0 -> 1 word, 31 -> 32 words)
wr_data  in  DATA_W  write word, consumed on wr_valid & wr_ready
wr_valid  in  1  write word offered
wr_ready  out  1  write word accepted
resp_data  out  DATA_W  read word
resp_valid  out  1  read word available
resp_ready  in  1  host accepts read word
master_has_control  out  1  to access mux select
master_read_addr  out  ADDR_W  to access mux
master_write_addr  out  ADDR_W  to access mux
master_write  out  1  write strobe to access mux
read_node  in  DATA_W  memory read data
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, any state, including mid-burst): state IDLE; master_has_control=0, master_write=0, both addresses=0, cmd_ready=0, wr_ready=0, resp_valid=0, resp_data=0, busy=0. Partially executed bursts are abandoned; already-written words remain.
- States: IDLE, ACQUIRE, WRITE, READ_WAIT, READ_HOLD, RELEASE.
- IDLE: cmd_ready=1. On accept, latch write/addr/len; go ACQUIRE; raise master_has_control next cycle.
- ACQUIRE: master_has_control=1, master_write=0; count SWITCH_CYCLES cycles, then WRITE or READ_WAIT.
- WRITE: wr_ready=1. On wr_valid: master_write_addr=current addr, master_write=1 for exactly that one cycle, data presented to the mux write path that same cycle. No wr_valid -> master_write=0, stall with no timeout.
- READ_WAIT: master_read_addr=current addr; wait READ_LATENCY cycles (0 = sample same cycle), capture read_node into resp_data, go READ_HOLD with resp_valid=1.
- READ_HOLD: resp_data/resp_valid held stable until resp_ready; on handshake resp_valid drops the next cycle; next word or RELEASE.
- Address increments mod 32 per word (31 -> 0 wraps, no error). Word count reaches len+1 -> RELEASE.
- RELEASE: master_write=0, master_has_control held SWITCH_CYCLES cycles then dropped; IDLE. cmd_ready stays 0 until IDLE (min two idle-to-idle commands separated by 2*SWITCH_CYCLES+2 cycles).
- cmd_valid while busy: ignored, not queued. wr_valid during reads: ignored, wr_ready=0.
- master_write never asserted while master_has_control=0 or during ACQUIRE/RELEASE guard.

Optional Feature:
RVPI_MASTER_VERIFY_EN: defined -> after each write, one readback at the same address (READ_LATENCY wait). Mismatch sets sticky output verify_err (1 bit, cleared by reset or next cmd accept). Throughput: one word per 2+READ_LATENCY cycles. Undefined -> no readback; verify_err port absent; one word per cycle.

Decomposition:
- Shared package rvpi_pkg: ADDR_W/DATA_W constants, memory depth 32, state encoding typedef, command struct (write, addr, len).
- One sub-module: rvpi_guard_counter (load SWITCH_CYCLES, count down, done pulse), used by ACQUIRE and RELEASE.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, cmd_ready=1 from first post-reset cycle.
- Write addr 3 len 0 data 12'hA5C -> master_has_control high for 2+1+2 cycles, master_write single pulse with write_addr=3; read addr 3 then returns 12'hA5C.
- Write burst addr 30 len 3 data 1,2,3,4 -> words at 30,31,0,1; read burst addr 30 len 3 returns 1,2,3,4 in order.
- Read burst len 1 with resp_ready held low 5 cycles -> resp_valid/resp_data stable, no address advance until handshake.
- Assert reset mid write burst after 2 of 4 words -> outputs zero immediately (async), those 2 words persist, remaining addresses unchanged.
- VERIFY_EN, memory model forced to corrupt address 7 -> write 12'h123 to 7 sets verify_err=1; next command accept clears it.

Source files
------------

// File: rtl/rvpi_pkg.sv
// rvpi_pkg: shared widths, FSM state encoding and latched command format for the rvpi master port
package rvpi_pkg;
  localparam int RVPI_ADDR_W = 5;
  localparam int RVPI_DATA_W = 12;
  localparam int RVPI_DEPTH = 32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQUIRE,
    S_WRITE,
    S_READ_WAIT,
    S_READ_HOLD,
    S_RELEASE
  } state_t;
  typedef struct packed {
    logic write;
    logic [RVPI_ADDR_W-1:0] addr;
    logic [RVPI_ADDR_W-1:0] len;
  } cmd_t;
endpackage

// File: rtl/rvpi_guard_counter.sv
// rvpi_guard_counter: SWITCH_CYCLES guard timer for taking and releasing the access mux
//   clk, reset : clock, asynchronous active-high reset
//   i_run      : high while in a guard state; low reloads the count
//   o_done     : high during the last guard cycle
module rvpi_guard_counter #(
  parameter int CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_done
);
  logic [2:0] r_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= 3'(CYCLES);
    else r_cnt <= i_run ? r_cnt - 3'd1 : 3'(CYCLES);
  end
  assign o_done = i_run && r_cnt == 3'd1;
endmodule

// File: rtl/rvpi_master_port.sv
// rvpi_master_port: burst read/write master for the shared 32x12 slave memory via the access mux
//   cmd_*      : host command channel (valid/ready), write flag, start address, length-1
//   wr_*       : host write-data channel; wr_data feeds the mux write path directly
//   resp_*     : read-data response channel
//   master_*   : master leg of the access mux; read_node is the memory read data
//   busy       : high outside IDLE
//   verify_err : sticky readback mismatch, present only with RVPI_MASTER_VERIFY_EN
module rvpi_master_port
  import rvpi_pkg::*;
#(
  parameter int ADDR_W = RVPI_ADDR_W,
  parameter int DATA_W = RVPI_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int SWITCH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              master_has_control,
  output logic [ADDR_W-1:0] master_read_addr,
  output logic [ADDR_W-1:0] master_write_addr,
  output logic              master_write,
  input  logic [DATA_W-1:0] read_node,
  output logic              busy
`ifdef RVPI_MASTER_VERIFY_EN
  ,output logic             verify_err
`endif
);
  state_t r_state;
  cmd_t r_cmd;
  logic [ADDR_W-1:0] r_cnt;
  logic [1:0] r_lat;
  logic r_has;
  logic r_rdy;
  logic r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic w_done;
  logic w_last;
  logic w_smp;
  rvpi_guard_counter #(.CYCLES(SWITCH_CYCLES)) u_guard (
    .clk(clk),
    .reset(reset),
    .i_run(r_state == S_ACQUIRE || r_state == S_RELEASE),
    .o_done(w_done)
  );
  assign w_last = r_cnt == r_cmd.len;
  assign w_smp = r_state == S_READ_WAIT && r_lat == 2'(READ_LATENCY);
  assign cmd_ready = r_rdy;
  assign busy = r_state != S_IDLE;
  assign wr_ready = r_state == S_WRITE;
  // write strobe is combinational so wr_data reaches the mux in its own handshake cycle
  assign master_write = r_state == S_WRITE && wr_valid && r_has;
  assign master_write_addr = r_cmd.addr;
  assign master_read_addr = r_cmd.addr;
  assign master_has_control = r_has;
  assign resp_valid = r_rvalid;
  assign resp_data = r_rdata;
`ifdef RVPI_MASTER_VERIFY_EN
  logic [DATA_W-1:0] r_wdata;
  logic r_err;
  assign verify_err = r_err;
`else
  logic w_unused;
  assign w_unused = ^wr_data;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cmd <= '0;
      r_cnt <= '0;
      r_lat <= '0;
      r_has <= 1'b0;
      r_rdy <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata <= '0;
`ifdef RVPI_MASTER_VERIFY_EN
      r_wdata <= '0;
      r_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (cmd_valid && r_rdy) begin
            r_cmd <= '{write: cmd_write, addr: cmd_addr, len: cmd_len};
            r_cnt <= '0;
            r_rdy <= 1'b0;
            r_has <= 1'b1;
            r_state <= S_ACQUIRE;
`ifdef RVPI_MASTER_VERIFY_EN
            r_err <= 1'b0;
`endif
          end
        end
        S_ACQUIRE: if (w_done) r_state <= r_cmd.write ? S_WRITE : S_READ_WAIT;
        S_WRITE: begin
          if (wr_valid) begin
`ifdef RVPI_MASTER_VERIFY_EN
            // hold the address for the readback of the word just written
            r_wdata <= wr_data;
            r_state <= S_READ_WAIT;
`else
            r_cmd.addr <= r_cmd.addr + 1'b1;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_state <= S_RELEASE;
`endif
          end
        end
        S_READ_WAIT: begin
          r_lat <= w_smp ? 2'd0 : r_lat + 2'd1;
          if (w_smp) begin
`ifdef RVPI_MASTER_VERIFY_EN
            if (r_cmd.write) begin
              if (read_node != r_wdata) r_err <= 1'b1;
              r_cmd.addr <= r_cmd.addr + 1'b1;
              r_cnt <= r_cnt + 1'b1;
              r_state <= w_last ? S_RELEASE : S_WRITE;
            end else begin
              r_rdata <= read_node;
              r_rvalid <= 1'b1;
              r_state <= S_READ_HOLD;
            end
`else
            r_rdata <= read_node;
            r_rvalid <= 1'b1;
            r_state <= S_READ_HOLD;
`endif
          end
        end
        S_READ_HOLD: begin
          if (resp_ready) begin
            r_rvalid <= 1'b0;
            r_cmd.addr <= r_cmd.addr + 1'b1;
            r_cnt <= r_cnt + 1'b1;
            r_state <= w_last ? S_RELEASE : S_READ_WAIT;
          end
        end
        S_RELEASE: begin
          if (w_done) begin
            r_has <= 1'b0;
            r_rdy <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
